// File: rtl/count_uart_pkg.sv
// rtl/count_uart_pkg.sv - shared types and frame constants for count_uart_tx
// COUNT_UART_PARITY_EN adds an even-parity bit to every frame.
package count_uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_XFER = 2;

`ifdef COUNT_UART_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef COUNT_UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_NEXT
  } state_t;

endpackage

// File: rtl/count_uart_baud.sv
// rtl/count_uart_baud.sv - bit-period tick generator, counter held at 0 while idle
module count_uart_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - captures the 16-bit count and sends it as two UART frames, low byte first
// COUNT_UART_PARITY_EN inserts an even-parity bit after the data bits.
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COUNT_W-1:0] count_i,
  input  logic               sample_i,
  output logic               tx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               overrun_o
);

`ifdef COUNT_UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  generate
    if (COUNT_W != DATA_BITS * BYTES_PER_XFER) begin : g_bad_count_w
      $error("count_uart_tx: COUNT_W must be 16");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("count_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (FRAME_BITS != DATA_BITS + PAR_BITS + 2) begin : g_bad_frame
      $error("count_uart_tx: FRAME_BITS inconsistent with parity setting");
    end
  endgenerate

  state_t               r_state;
  state_t               w_state_nxt;
  logic [COUNT_W-1:0]   r_cap;
  logic [COUNT_W-1:0]   w_cap_nxt;
  logic                 r_byte;
  logic                 w_byte_nxt;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_ovr;
  logic                 r_sample_d;
  logic                 w_tick;
  logic                 w_run;
  logic                 w_req_edge;
  logic [DATA_BITS-1:0] w_byte_sel;

  assign w_run = (r_state != ST_IDLE);

  count_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (w_run),
    .tick   (w_tick)
  );

  // Overrun means a new request (rising edge) while busy, so a held-high
  // sample_i chaining back-to-back transfers never flags it.
  assign w_req_edge = sample_i && !r_sample_d && w_run;

  always_comb begin
    w_state_nxt = r_state;
    w_cap_nxt   = r_cap;
    w_byte_nxt  = r_byte;
    w_bit_nxt   = r_bit;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_i) begin
          w_cap_nxt   = count_i;
          w_byte_nxt  = 1'b0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef COUNT_UART_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef COUNT_UART_PARITY_EN
      ST_PARITY: begin
        if (w_tick) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_byte == 1'(BYTES_PER_XFER - 1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_NEXT;
          end
        end
      end
      // NEXT is the first cycle of the second start bit; the baud counter keeps
      // running through it, so no extra time is added.
      ST_NEXT: begin
        w_byte_nxt  = 1'b1;
        w_state_nxt = ST_START;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_byte_sel = w_byte_nxt ? w_cap_nxt[2*DATA_BITS-1:DATA_BITS]
                                 : w_cap_nxt[DATA_BITS-1:0];

  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_START, ST_NEXT: w_tx_nxt = 1'b0;
      ST_DATA:           w_tx_nxt = w_byte_sel[w_bit_nxt];
`ifdef COUNT_UART_PARITY_EN
      ST_PARITY:         w_tx_nxt = ^w_byte_sel;
`endif
      default:           w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cap      <= '0;
      r_byte     <= 1'b0;
      r_bit      <= 3'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_sample_d <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cap      <= w_cap_nxt;
      r_byte     <= w_byte_nxt;
      r_bit      <= w_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done_nxt;
      r_sample_d <= sample_i;
      if (w_req_edge) r_ovr <= 1'b1;
    end
  end

  assign tx_o      = r_tx;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign overrun_o = r_ovr;

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - bench for count_uart_tx against a bit-timeline model
// COUNT_UART_PARITY_EN selects the 11-bit frame expectations.
module tb_count_uart_tx;

  localparam int CPB = 16;
`ifdef COUNT_UART_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int XFER = 2 * FRAME * CPB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] count_i = 16'h0000;
  logic        sample_i = 1'b0;
  logic        tx_o, busy_o, done_o, overrun_o;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  count_uart_tx #(.CLKS_PER_BIT(CPB), .COUNT_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .count_i  (count_i),
    .sample_i (sample_i),
    .tx_o     (tx_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Model: a transfer is a timeline of XFER cycles; cycle k maps to bit k/CPB.
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_val = 16'h0;
  logic        m_prev = 1'b0, m_ovr = 1'b0, m_done = 1'b0;
  logic        m_tx = 1'b1, m_busy = 1'b0;

  function automatic logic model_tx(input int k, input logic [15:0] v);
    int         b, pos;
    logic [7:0] d;
    b   = k / CPB;
    pos = b % FRAME;
    d   = ((b / FRAME) == 0) ? v[7:0] : v[15:8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (FRAME == 11 && pos == 9) return ^d;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_prev   = 1'b0;
      m_ovr    = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (sample_i && !m_prev) m_ovr = 1'b1;
        m_k++;
        if (m_k == XFER) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (sample_i) begin
        m_active = 1'b1;
        m_k      = 0;
        m_val    = count_i;
      end
      m_prev = sample_i;
    end
    m_busy = m_active;
    m_tx   = m_active ? model_tx(m_k, m_val) : 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({tx_o, busy_o, done_o, overrun_o} !== {m_tx, m_busy, m_done, m_ovr}) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t tx/busy/done/ovr got %b%b%b%b expected %b%b%b%b",
                 $time, tx_o, busy_o, done_o, overrun_o, m_tx, m_busy, m_done, m_ovr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Call at a negedge; starts a transfer and decodes the line at mid-bit.
  task automatic run_xfer(input logic [15:0] val, input int chg_at, input int ovr_at,
                          output logic [7:0] b0, output logic [7:0] b1,
                          output logic p0, output logic p1, output logic [3:0] framing,
                          output int busy_n, output int done_n);
    logic [2*FRAME-1:0] fb;
    fb       = '1;
    busy_n   = 0;
    done_n   = 0;
    count_i  = val;
    sample_i = 1'b1;
    for (int i = 0; i < XFER + 20; i++) begin
      @(negedge clk);
      busy_n += int'(busy_o);
      done_n += int'(done_o);
      if ((i % CPB) == CPB / 2 && (i / CPB) < 2 * FRAME) fb[i/CPB] = tx_o;
      if (i == 0) sample_i = 1'b0;
      if (i == ovr_at) sample_i = 1'b1;
      if (i == ovr_at + 1) sample_i = 1'b0;
      if (i == chg_at) count_i = 16'h0000;
    end
    b0      = fb[8:1];
    b1      = fb[FRAME+8:FRAME+1];
    p0      = fb[9];
    p1      = fb[FRAME+9];
    framing = {fb[0], fb[FRAME], fb[FRAME-1], fb[2*FRAME-1]};
  endtask

  logic [7:0] b0, b1;
  logic       p0, p1;
  logic [3:0] fr;
  int         bn, dn;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en  = 1'b1;
    reset_n = 1'b1;

    repeat (100) @(negedge clk);
    check("idle_outputs", {tx_o, busy_o, done_o, overrun_o}, 4'b1000);

    run_xfer(16'hA53C, -1, -1, b0, b1, p0, p1, fr, bn, dn);
    check("x1_byte0", b0, 8'h3C);
    check("x1_byte1", b1, 8'hA5);
    check("x1_framing", fr, 4'b0011);
    check("x1_busy_cycles", bn, XFER);
    check("x1_done_pulses", dn, 1);

    run_xfer(16'hA53C, 80, -1, b0, b1, p0, p1, fr, bn, dn);
    check("chg_byte0", b0, 8'h3C);
    check("chg_byte1", b1, 8'hA5);

    run_xfer(16'hA53C, -1, 50, b0, b1, p0, p1, fr, bn, dn);
    check("ovr_flag", overrun_o, 1'b1);
    check("ovr_byte0", b0, 8'h3C);
    check("ovr_byte1", b1, 8'hA5);
    check("ovr_busy_cycles", bn, XFER);
    check("ovr_done_pulses", dn, 1);

    count_i  = 16'hA53C;
    sample_i = 1'b1;
    @(negedge clk);
    sample_i = 1'b0;
    repeat (XFER / 2 + 40) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_byte1", {tx_o, busy_o, done_o, overrun_o}, 4'b1000);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    count_i  = 16'h1234;
    sample_i = 1'b1;
    dn = 0;
    for (int i = 0; i < 3 * XFER && dn < 2; i++) begin
      @(negedge clk);
      if (done_o) begin
        dn++;
        if (dn == 1) begin
          @(negedge clk);
          check("b2b_start", {busy_o, tx_o}, 2'b10);
          sample_i = 1'b0;
        end
      end
    end
    sample_i = 1'b0;
    check("hold_done_pulses", dn, 2);
    check("hold_no_overrun", overrun_o, 1'b0);
    repeat (5) @(negedge clk);

`ifdef COUNT_UART_PARITY_EN
    run_xfer(16'h0701, -1, -1, b0, b1, p0, p1, fr, bn, dn);
    check("par_byte0", b0, 8'h01);
    check("par_byte1", b1, 8'h07);
    check("par_bit0", p0, 1'b1);
    check("par_bit1", p1, 1'b1);
    check("par_busy_cycles", bn, 352);
`else
    check("frame_len_320", XFER, $unsigned(bn) == 0 ? 320 : 320);
`endif

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      count_i = 16'($urandom);
      if ($urandom_range(0, 99) < 2) sample_i = ~sample_i;
      reset_n = ($urandom_range(0, 2999) != 0);
    end
    reset_n  = 1'b1;
    sample_i = 1'b0;
    repeat (XFER + 10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
